int_ctrl: RTL

- Interrupt request side of the CPU's four vectored interrupt lines (ie1..ie4).
- Synchronises four external or timer request inputs and latches their rising edges as pending bits.
- Applies a mask and a global enable, selects one request by fixed priority, and drives exactly one ie line for one clock cycle.
- Blocks further requests until the CPU signals return-from-interrupt. It sits between the I/O pins and timer on one side and the datapath's interrupt inputs on the other.

---
 rtl/int_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - four-source vectored interrupt controller with one-cycle ie strobes.
// Define INTC_NESTING_EN to allow higher-priority requests to preempt one being serviced.
module int_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] irq,
    input  logic       we_mask,
    input  logic [3:0] mask_in,
    input  logic       ei,
    input  logic       di,
    input  logic       reti,
    output logic       ie1,
    output logic       ie2,
    output logic       ie3,
    output logic       ie4,
    output logic [3:0] pending,
    output logic [3:0] in_service,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, FIRE, SVC} state_t;

    state_t     state;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] prev_q;
    logic [3:0] pending_q;
    logic [3:0] in_service_q;
    logic [3:0] mask_q;
    logic       gie_q;
    logic [3:0] ie_q;

    logic [3:0] rise;
    logic [3:0] eligible;
    logic [3:0] win_oh;
    logic       take;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign eligible = pending_q & mask_q & {4{gie_q}};
    // Isolate the lowest set bit: lowest index is highest priority.
    assign win_oh   = eligible & (~eligible + 4'd1);

`ifdef INTC_NESTING_EN
    logic [3:0] svc_top;
    logic [3:0] svc_after_reti;
    assign svc_top        = in_service_q & (~in_service_q + 4'd1);
    assign svc_after_reti = in_service_q & ~svc_top;
`endif

    always_comb begin
        take = 1'b0;
        case (state)
            IDLE: take = |eligible;
`ifdef INTC_NESTING_EN
            // Preempt only if the winner sits strictly below every active source.
            SVC:  take = !reti && (|(win_oh & (svc_top - 4'd1)));
`endif
            default: take = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pending_q    <= '0;
            in_service_q <= '0;
            mask_q       <= '0;
            gie_q        <= 1'b0;
            ie_q         <= '0;
        end else begin
            // A fresh edge in the same cycle as selection keeps the request pending.
            pending_q <= (pending_q & ~(take ? win_oh : 4'b0000)) | rise;
            if (we_mask) begin
                mask_q <= mask_in;
            end
            if (di) begin
                gie_q <= 1'b0;
            end else if (ei) begin
                gie_q <= 1'b1;
            end
            ie_q <= '0;
            case (state)
                IDLE: begin
                    if (take) begin
                        in_service_q <= in_service_q | win_oh;
                        ie_q         <= win_oh;
                        state        <= FIRE;
                    end
                end
                FIRE: state <= SVC;
                SVC: begin
                    if (reti) begin
`ifdef INTC_NESTING_EN
                        in_service_q <= svc_after_reti;
                        if (svc_after_reti == 4'b0000) begin
                            state <= IDLE;
                        end
`else
                        in_service_q <= '0;
                        state        <= IDLE;
`endif
                    end else if (take) begin
                        in_service_q <= in_service_q | win_oh;
                        ie_q         <= win_oh;
                        state        <= FIRE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ie1        = ie_q[0];
    assign ie2        = ie_q[1];
    assign ie3        = ie_q[2];
    assign ie4        = ie_q[3];
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign busy       = |in_service_q;

endmodule
